// File: rtl/isp_stream_ctrl.sv
// ISP front-end stream controller: raster/Bayer tracking, sof/eol/eof tagging, frame-boundary
// mode shadowing, completed-frame counting and sticky abort flag. Two-stage registered output path.
module isp_stream_ctrl #(
   parameter int unsigned DW    = 16,
   parameter int unsigned PW    = 12,
   parameter int unsigned HW    = 12,
   parameter int unsigned VW    = 12,
   parameter int unsigned NMODE = 3,
   parameter int unsigned FCW   = 16
) (
   input  logic             isp_clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    data_in_i,
   input  logic             data_en_i,
   input  logic             vs_in_i,
   input  logic [HW-1:0]    h_active_i,
   input  logic [VW-1:0]    v_active_i,
   input  logic [1:0]       bayer_start_i,
   input  logic [NMODE-1:0] mode_sel_i,
   input  logic             err_clr_i,
   output logic [PW-1:0]    pix_out_o,
   output logic [3:0]       bayer_tag_o,
   output logic             pix_valid_o,
   output logic             sof_o,
   output logic             eol_o,
   output logic             eof_o,
   output logic [NMODE-1:0] path_en_o,
   output logic [FCW-1:0]   frames_cnt_o,
   output logic             frame_err_o
);

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e          state_q;
   logic [HW-1:0]   h_q, h_act_q;
   logic [VW-1:0]   v_q, v_act_q;
   logic [1:0]      bstart_q;
   logic            frame_err_q;

   logic             s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
   logic [PW-1:0]    s1_pix_q;
   logic [3:0]       s1_tag_q;
   logic [NMODE-1:0] s1_mode_q;

   logic [NMODE-1:0] path_en_q;
   logic [FCW-1:0]   frames_q;
   logic [PW-1:0]    pix_q;
   logic [3:0]       tag_q;
   logic             valid_q, sof_q, eol_q, eof_q;

   logic [NMODE-1:0] mode_onehot;
   logic             restart, zero_geom, accept, abort, eol, eof;
   logic [HW-1:0]    h_cur, h_act;
   logic [VW-1:0]    v_cur, v_act;
   logic [1:0]       bstart, phase;

   // Highest set request bit wins.
   always_comb begin
      mode_onehot = '0;
      for (int i = 0; i < int'(NMODE); i++) begin
         if (mode_sel_i[i]) begin
            mode_onehot    = '0;
            mode_onehot[i] = 1'b1;
         end
      end
   end

   // A restart pixel is (0,0) of a new frame and sees the live geometry instead of the shadows.
   always_comb begin
      restart   = data_en_i && ((state_q == StIdle) || vs_in_i);
      abort     = vs_in_i && (state_q == StActive);
      h_act     = restart ? h_active_i : h_act_q;
      v_act     = restart ? v_active_i : v_act_q;
      bstart    = restart ? bayer_start_i : bstart_q;
      h_cur     = restart ? '0 : h_q;
      v_cur     = restart ? '0 : v_q;
      zero_geom = restart && ((h_active_i == '0) || (v_active_i == '0));
      accept    = data_en_i && !zero_geom;
      eol       = (h_cur == h_act - HW'(1));
      eof       = eol && (v_cur == v_act - VW'(1));
      phase     = bstart ^ {v_cur[0], h_cur[0]};
   end

   always_ff @(posedge isp_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         h_q         <= '0;
         v_q         <= '0;
         h_act_q     <= '0;
         v_act_q     <= '0;
         bstart_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         if (abort) begin
            frame_err_q <= 1'b1;
         end else if (err_clr_i) begin
            frame_err_q <= 1'b0;
         end
         if (vs_in_i) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
         end
         if (accept) begin
            if (restart) begin
               h_act_q  <= h_active_i;
               v_act_q  <= v_active_i;
               bstart_q <= bayer_start_i;
            end
            if (eof) begin
               state_q <= StIdle;
               h_q     <= '0;
               v_q     <= '0;
            end else if (eol) begin
               state_q <= StActive;
               h_q     <= '0;
               v_q     <= v_cur + VW'(1);
            end else begin
               state_q <= StActive;
               h_q     <= h_cur + HW'(1);
               v_q     <= v_cur;
            end
         end
      end
   end

   always_ff @(posedge isp_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sof_q   <= 1'b0;
         s1_eol_q   <= 1'b0;
         s1_eof_q   <= 1'b0;
         s1_pix_q   <= '0;
         s1_tag_q   <= '0;
         s1_mode_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         s1_sof_q   <= accept && restart;
         s1_eol_q   <= accept && eol;
         s1_eof_q   <= accept && eof;
         s1_pix_q   <= accept ? data_in_i[DW-1 -: PW] : '0;
         s1_tag_q   <= accept ? (4'b0001 << phase) : 4'b0000;
         if (accept && restart) begin
            s1_mode_q <= mode_onehot;
         end
      end
   end

   always_ff @(posedge isp_clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
         pix_q     <= '0;
         tag_q     <= '0;
         path_en_q <= '0;
         frames_q  <= '0;
      end else begin
         valid_q <= s1_valid_q;
         sof_q   <= s1_sof_q;
         eol_q   <= s1_eol_q;
         eof_q   <= s1_eof_q;
         pix_q   <= s1_pix_q;
         tag_q   <= s1_tag_q;
         if (s1_sof_q) begin
            path_en_q <= s1_mode_q;
         end
         if (s1_eof_q) begin
            frames_q <= frames_q + FCW'(1);
         end
      end
   end

   if (PW < DW) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^data_in_i[DW-PW-1:0];
   end

   assign pix_out_o    = pix_q;
   assign bayer_tag_o  = tag_q;
   assign pix_valid_o  = valid_q;
   assign sof_o        = sof_q;
   assign eol_o        = eol_q;
   assign eof_o        = eof_q;
   assign path_en_o    = path_en_q;
   assign frames_cnt_o = frames_q;
   assign frame_err_o  = frame_err_q;

endmodule
